// File: rtl/io_pkg.sv
// Shared constants and types for the board-input conditioner and its CPU bus decoder.
package io_pkg;

  localparam int NUM_BTN_DEF = 4;
  localparam int SW_W_DEF    = 16;

  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;

  // Byte offsets within the I/O window, decoded by the CPU bus.
  localparam logic [7:0] IO_OFF_BTN_LEVEL = 8'h00;
  localparam logic [7:0] IO_OFF_SW        = 8'h04;
  localparam logic [7:0] IO_OFF_STICKY    = 8'h08;
  localparam logic [7:0] IO_OFF_STICKY_CLR = 8'h0C;

  typedef struct packed {
    logic level;
    logic press;
    logic rel;
    logic sticky;
  } btn_stat_t;

endpackage

// File: rtl/debounce_chan.sv
// One button channel: 2-flop sync, debounce counter, edge pulses, sticky flag.
// Auto-repeat pulses are added when AUTO_REPEAT_EN is defined.
module debounce_chan
  import io_pkg::*;
#(
  parameter int DEBOUNCE_CYC  = 16,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      raw,
  input  logic      clr,
  output btn_stat_t stat
);

  localparam int CW = $clog2(DEBOUNCE_CYC);

  if (DEBOUNCE_CYC < 2) begin : g_bad_debounce
    $error("debounce_chan: DEBOUNCE_CYC must be >= 2");
  end
  if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
    $error("debounce_chan: REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic          s1, s2, level, press, rel, sticky;
  logic [CW-1:0] cnt;
  logic          accept, rise, fall, rpt_fire, press_set;

  assign accept    = (s2 != level) && (cnt == CW'(DEBOUNCE_CYC - 1));
  assign rise      = accept & s2;
  assign fall      = accept & ~s2;
  assign press_set = rise | rpt_fire;

`ifdef AUTO_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RW   = (RMAX > 1) ? $clog2(RMAX) : 1;

  logic [RW-1:0] rcnt;
  logic          rphase; // 0: waiting out the initial delay, 1: periodic

  assign rpt_fire = level & ~accept &
                    (rcnt == (rphase ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end else if (!level || accept) begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end else if (rpt_fire) begin
      rcnt   <= '0;
      rphase <= 1'b1;
    end else begin
      rcnt   <= rcnt + 1'b1;
    end
  end
`else
  assign rpt_fire = 1'b0;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1     <= 1'b0;
      s2     <= 1'b0;
      cnt    <= '0;
      level  <= 1'b0;
      press  <= 1'b0;
      rel    <= 1'b0;
      sticky <= 1'b0;
    end else begin
      s1    <= raw;
      s2    <= s1;
      press <= press_set;
      rel   <= fall;
      // A press landing on the same edge as a clear must survive it.
      sticky <= press_set | (sticky & ~clr);
      if (s2 == level) begin
        cnt <= '0;
      end else if (accept) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign stat = '{level: level, press: press, rel: rel, sticky: sticky};

endmodule

// File: rtl/io_input_conditioner.sv
// Board-input front end: NUM_BTN debounced button channels plus synchronised switches.
// Optional auto-repeat on held buttons is enabled by defining AUTO_REPEAT_EN.
module io_input_conditioner
  import io_pkg::*;
#(
  parameter int NUM_BTN       = NUM_BTN_DEF,
  parameter int SW_W          = SW_W_DEF,
  parameter int DEBOUNCE_CYC  = 16,
  parameter int REPEAT_DELAY  = 64,
  parameter int REPEAT_PERIOD = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_BTN-1:0] btn_raw,
  input  logic [SW_W-1:0]    sw_raw,
  input  logic               clr_we,
  input  logic [NUM_BTN-1:0] clr_mask,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_sticky,
  output logic [SW_W-1:0]    sw_sync
);

  logic [SW_W-1:0] sw_s1;
  btn_stat_t       stat [NUM_BTN];

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_btn
    debounce_chan #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .raw  (btn_raw[i]),
      .clr  (clr_we & clr_mask[i]),
      .stat (stat[i])
    );
    assign btn_level[i]   = stat[i].level;
    assign btn_press[i]   = stat[i].press;
    assign btn_release[i] = stat[i].rel;
    assign btn_sticky[i]  = stat[i].sticky;
  end

  // Switches are level inputs read by software; synchronise only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sw_s1   <= '0;
      sw_sync <= '0;
    end else begin
      sw_s1   <= sw_raw;
      sw_sync <= sw_s1;
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Directed bench for io_input_conditioner with DEBOUNCE_CYC=4; repeat checks when AUTO_REPEAT_EN is defined.
module tb_io_input_conditioner;

  localparam int NB = 4;
  localparam int SW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [NB-1:0] btn_raw, clr_mask;
  logic [SW-1:0] sw_raw;
  logic          clr_we;
  logic [NB-1:0] btn_level, btn_press, btn_release, btn_sticky;
  logic [SW-1:0] sw_sync;

  int total = 0;
  int bad   = 0;

  io_input_conditioner #(
    .NUM_BTN(NB), .SW_W(SW), .DEBOUNCE_CYC(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(4)
  ) dut (
    .clk(clk), .reset(reset), .btn_raw(btn_raw), .sw_raw(sw_raw),
    .clr_we(clr_we), .clr_mask(clr_mask), .btn_level(btn_level),
    .btn_press(btn_press), .btn_release(btn_release), .btn_sticky(btn_sticky),
    .sw_sync(sw_sync)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] lv, input logic [3:0] pr,
                         input logic [3:0] rl, input logic [3:0] st);
    chk({tag, ".level"},   32'(btn_level),   32'(lv));
    chk({tag, ".press"},   32'(btn_press),   32'(pr));
    chk({tag, ".release"}, 32'(btn_release), 32'(rl));
    chk({tag, ".sticky"},  32'(btn_sticky),  32'(st));
  endtask

  initial begin
    reset = 1'b1; btn_raw = 4'b1111; sw_raw = 16'hFFFF; clr_we = 1'b0; clr_mask = '0;
    tick(); tick(); tick();
    chk_all("rst", 4'h0, 4'h0, 4'h0, 4'h0);
    chk("rst.sw", 32'(sw_sync), 32'h0);
    reset = 1'b0;
    tick(); chk("rst.sw1", 32'(sw_sync), 32'h0);
    tick(); chk("rst.sw2", 32'(sw_sync), 32'hFFFF);
    tick(); tick(); tick();
    chk("rst.lvl5", 32'(btn_level), 32'h0);
    tick(); chk_all("rst.acc", 4'hF, 4'hF, 4'h0, 4'hF);
    tick(); chk_all("rst.post", 4'hF, 4'h0, 4'h0, 4'hF);

`ifdef AUTO_REPEAT_EN
    btn_raw = 4'b0000;
    for (int i = 0; i < 6; i++) tick();
    chk_all("rp.rel", 4'h0, 4'h0, 4'hF, 4'hF);
    btn_raw = 4'b0001;
    for (int i = 0; i < 6; i++) tick();
    chk("rp.acc", 32'(btn_press), 32'h1);
    for (int k = 1; k <= 45; k++) begin
      if (k == 31) btn_raw = 4'b0000;
      tick();
      chk($sformatf("rp.k%0d", k), 32'(btn_press),
          32'((k >= 8 && k < 36 && (k - 8) % 4 == 0) ? 1 : 0));
      if (k == 36) chk("rp.relacc", 32'(btn_release), 32'h1);
    end
`else
    clr_we = 1'b1; clr_mask = 4'hF; tick(); clr_we = 1'b0;
    chk("clr.all", 32'(btn_sticky), 32'h0);
    btn_raw = 4'b0000;
    for (int i = 0; i < 5; i++) tick();
    chk("rel.lvl5", 32'(btn_level), 32'hF);
    tick(); chk_all("rel.acc", 4'h0, 4'h0, 4'hF, 4'h0);
    tick(); chk("rel.post", 32'(btn_release), 32'h0);

    sw_raw = 16'hA5A5;
    tick(); chk("sw.1", 32'(sw_sync), 32'hFFFF);
    tick(); chk("sw.2", 32'(sw_sync), 32'hA5A5);

    // Bounce on button 1: 2-cycle pulses never reach the 4-cycle threshold.
    for (int i = 0; i < 10; i++) begin
      btn_raw[1] = (i % 2 == 0);
      tick(); chk("bnc.p", 32'(btn_press | btn_level), 32'h0);
      tick(); chk("bnc.p", 32'(btn_press | btn_level), 32'h0);
    end
    btn_raw[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick(); chk("bnc.wait", 32'(btn_press), 32'h0);
    end
    tick(); chk_all("bnc.acc", 4'b0010, 4'b0010, 4'h0, 4'b0010);

    // Clean press on button 0 with a clear of bit 0 landing on the press edge.
    btn_raw = 4'b0011;
    for (int i = 0; i < 5; i++) tick();
    chk("clean.lvl5", 32'(btn_level), 32'b0010);
    clr_we = 1'b1; clr_mask = 4'b0001;
    tick(); clr_we = 1'b0;
    chk_all("clean.acc", 4'b0011, 4'b0001, 4'h0, 4'b0011);
    tick(); chk_all("clean.post", 4'b0011, 4'h0, 4'h0, 4'b0011);
    clr_we = 1'b1; clr_mask = 4'b0001;
    tick(); clr_we = 1'b0;
    chk("clr.bit0", 32'(btn_sticky), 32'b0010);

    btn_raw = 4'b0000;
    for (int i = 0; i < 6; i++) tick();
    chk_all("rel2", 4'h0, 4'h0, 4'b0011, 4'b0010);
    clr_we = 1'b1; clr_mask = 4'hF; tick(); clr_we = 1'b0;

    // Simultaneous press and release on buttons 1 and 3.
    btn_raw = 4'b1010;
    for (int i = 0; i < 6; i++) tick();
    chk_all("multi.p", 4'b1010, 4'b1010, 4'h0, 4'b1010);
    tick(); chk("multi.p1", 32'(btn_press), 32'h0);
    btn_raw = 4'b0000;
    for (int i = 0; i < 6; i++) tick();
    chk_all("multi.r", 4'h0, 4'h0, 4'b1010, 4'b1010);
    tick(); chk("multi.r1", 32'(btn_release), 32'h0);

    // Reset part-way through a debounce: full latency applies afterwards.
    btn_raw = 4'b0001;
    tick(); tick(); tick(); tick();
    reset = 1'b1; #1;
    chk_all("mid.rst", 4'h0, 4'h0, 4'h0, 4'h0);
    tick(); reset = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("mid.lvl5", 32'(btn_level), 32'h0);
    tick(); chk_all("mid.acc", 4'b0001, 4'b0001, 4'h0, 4'b0001);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
- Parametrised board-input front end between raw pushbuttons/switches and the CPU memory-mapped I/O.
- Each button channel gets a 2-flop synchroniser, a debounce counter, press/release edge pulses and a CPU-clearable sticky press flag.
- Switches are synchronised only.
- Successor to the fixed 4-button/16-switch hookup: channel count, switch width and debounce time are generalised.
- Adds edge detection, sticky latching and optional auto-repeat.

Parameters:
- NUM_BTN, 4, number of button channels (u, d, l, r order = bit 0..3 by default).
- SW_W, 16, switch bus width.
- DEBOUNCE_CYC, 16, consecutive stable cycles required to accept a level change; must be >= 2.
- REPEAT_DELAY, 64, cycles held before the first auto-repeat pulse. Used only with AUTO_REPEAT_EN.
- REPEAT_PERIOD, 16, cycles between later auto-repeat pulses. Used only with AUTO_REPEAT_EN.

Ports:
- clk  input  1  system clock; all logic rising-edge.
- reset  input  1  asynchronous, active-high reset.
- btn_raw  input  NUM_BTN  unsynchronised button levels.
- sw_raw  input  SW_W  unsynchronised switch levels.
- clr_we  input  1  sticky-clear strobe from CPU store.
- clr_mask  input  NUM_BTN  sticky bits to clear when clr_we=1.
- btn_level  output  NUM_BTN  debounced button level.
- btn_press  output  NUM_BTN  1-cycle pulse on accepted 0->1 (and on repeats when enabled).
- btn_release  output  NUM_BTN  1-cycle pulse on accepted 1->0.
- btn_sticky  output  NUM_BTN  set by btn_press, held until cleared.
- sw_sync  output  SW_W  synchronised switch levels.

Behaviour:
- Reset (asynchronous, active-high): all synchroniser flops, counters, btn_level, btn_press, btn_release, btn_sticky and sw_sync = 0. Outputs stay 0 until reset deasserts.
- Synchroniser: s1 <= raw, s2 <= s1. sw_sync = s2 of the switches, so latency is 2 cycles with no debounce.
- Debounce, per channel, counter width $clog2(DEBOUNCE_CYC):
  - If s2 == btn_level: counter <= 0.
  - Else if counter == DEBOUNCE_CYC-1: btn_level <= s2 and counter <= 0.
  - Else: counter <= counter+1.
- Latency from the raw edge: btn_level changes 2+DEBOUNCE_CYC cycles later.
- Glitch shorter than DEBOUNCE_CYC cycles at s2: counter returns to 0, no level change, no pulses.
- btn_press / btn_release are registered in the same cycle btn_level changes. Each is exactly 1 cycle wide and the two are never high together on one channel.
- Sticky, per bit:
  - btn_press=1 sets it.
  - clr_we & clr_mask clears it.
  - Set and clear in the same cycle: set wins.
  - clr_mask bits that are 0 leave their bits unaffected.
- Channels are fully independent; simultaneous events on several channels are each handled per channel.
- Reset mid-debounce discards partial counts.
- Parameter check: elaboration error if DEBOUNCE_CYC < 2.

Optional Feature:
- Macro AUTO_REPEAT_EN. Defined: adds a per-channel repeat counter.
- While btn_level=1, the first extra btn_press pulse fires REPEAT_DELAY cycles after the accepted press.
- Later pulses follow every REPEAT_PERIOD cycles.
- The repeat counter clears on btn_level=0 or reset.
- Each repeat pulse also sets btn_sticky.
- Undefined: no repeat logic; btn_press fires once per accepted press; the REPEAT_* parameters are ignored.

Decomposition:
- Shared package io_pkg holds:
  - default constants NUM_BTN_DEF=4 and SW_W_DEF=16;
  - button index constants BTN_U=0, BTN_D=1, BTN_L=2, BTN_R=3;
  - the MMIO offset constants used by the CPU bus decoder for sticky read/clear.
- Sub-module debounce_chan is natural: one button channel (sync, counter, level, edges, sticky, optional repeat), instantiated NUM_BTN times in a generate loop. The top adds the switch synchroniser.

Test Plan:
- Reset: reset=1 at t=0 with btn_raw=4'b1111 and sw_raw=16'hFFFF. Response: all outputs 0 while reset is high. After release, sw_sync=16'hFFFF 2 cycles later, btn_level=4'b1111 at 2+DEBOUNCE_CYC.
- Clean press, DEBOUNCE_CYC=4: btn_raw[0] 0->1 held. Response: btn_level[0]=1 exactly 6 cycles later, btn_press[0] a single 1-cycle pulse in that cycle, btn_sticky[0]=1 from that cycle on.
- Bounce, DEBOUNCE_CYC=4: btn_raw[1] toggles every 2 cycles for 20 cycles, then stays 1. Response: no btn_press[1] during the bounce, exactly one press 6 cycles after the final edge.
- Sticky clear race: clr_we=1 with clr_mask=4'b0001 in the same cycle as btn_press[0]. Response: btn_sticky[0] stays 1. The next clr_we with mask 4'b0001 clears it; other bits unchanged.
- Release and multi-channel: btn_raw=4'b1010 then 4'b0000. Response: press pulses on bits 1 and 3 in the same cycle, later release pulses on bits 1 and 3 together, btn_level returns to 0.
- AUTO_REPEAT_EN, REPEAT_DELAY=8, REPEAT_PERIOD=4, hold 30 cycles: btn_press pulses at accept+0, +8, +12, +16, ...; none after release.
